// File: rtl/seg_display_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seg_display_arbiter
// Function : Round-robin owner arbitration and anode scanning for a shared
//            four-digit multiplexed seven-segment display, three sources.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter logic [16:0] REFRESH_DIV = 17'd50_000,
    parameter logic [15:0] SLOT_FRAMES = 16'd250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [31:0] disp0,
    input  logic [31:0] disp1,
    input  logic [31:0] disp2,
    output logic [2:0]  gnt,
    output logic        busy,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t      r_state;
    logic [16:0] r_refresh_cnt;
    logic [1:0]  r_digit_sel;
    logic [15:0] r_frame_cnt;
    logic [1:0]  r_last_owner;
    logic [2:0]  r_gnt;

    logic        w_tick;
    logic        w_frame_end;
    logic        w_owner_req;
    logic        w_other_req;
    logic [1:0]  w_c1;
    logic [1:0]  w_c2;
    logic [1:0]  w_pick;
    logic        w_pick_valid;
    logic [31:0] w_image;
    logic [7:0]  w_digit;

    function automatic logic [1:0] f_next(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic [2:0] f_onehot(input logic [1:0] p);
        return 3'b001 << p;
    endfunction

    assign w_tick      = (r_refresh_cnt == REFRESH_DIV - 17'd1);
    assign w_frame_end = w_tick && (r_digit_sel == 2'd3);
    assign w_owner_req = |(req & r_gnt);
    assign w_other_req = |(req & ~r_gnt);
    assign w_c1        = f_next(r_last_owner);
    assign w_c2        = f_next(w_c1);

    // The previous owner is scanned last so a re-request never starves others.
    always_comb begin
        w_pick       = 2'd0;
        w_pick_valid = 1'b1;
        if (req[w_c1])
            w_pick = w_c1;
        else if (req[w_c2])
            w_pick = w_c2;
        else if (req[r_last_owner])
            w_pick = r_last_owner;
        else
            w_pick_valid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= '0;
        end else if (w_tick) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= r_digit_sel + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 17'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gnt        <= '0;
            r_last_owner <= 2'd2;
            r_frame_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_state      <= S_OWN;
                        r_gnt        <= f_onehot(w_pick);
                        r_last_owner <= w_pick;
                        r_frame_cnt  <= '0;
                    end
                end
                S_OWN: begin
                    if (w_frame_end && (r_frame_cnt != SLOT_FRAMES))
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    if (!w_owner_req || ((r_frame_cnt == SLOT_FRAMES) && w_other_req)) begin
                        r_state <= S_BLANK;
                        r_gnt   <= '0;
                    end
                end
                S_BLANK: begin
                    // Blank lasts until the next digit slot boundary to avoid ghosting.
                    if (w_tick) begin
                        if (w_pick_valid) begin
                            r_state      <= S_OWN;
                            r_gnt        <= f_onehot(w_pick);
                            r_last_owner <= w_pick;
                            r_frame_cnt  <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        case (r_last_owner)
            2'd1:    w_image = disp1;
            2'd2:    w_image = disp2;
            default: w_image = disp0;
        endcase
    end

    always_comb begin
        case (r_digit_sel)
            2'd1:    w_digit = w_image[15:8];
            2'd2:    w_digit = w_image[23:16];
            2'd3:    w_digit = w_image[31:24];
            default: w_digit = w_image[7:0];
        endcase
    end

    always_comb begin
        an  = 4'hF;
        seg = 8'hFF;
        if (r_state == S_OWN) begin
            an  = ~(4'b0001 << r_digit_sel);
            seg = w_digit;
        end
    end

    assign gnt  = r_gnt;
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seg_display_arbiter
// Function : Scoreboard bench: grant changes and display samples are queued
//            with their expected cycle and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b111;
    logic [31:0] disp0 = 32'hC0F9A4B0;
    logic [31:0] disp1 = 32'h8692F8A1;
    logic [31:0] disp2 = 32'h12345678;
    logic [2:0]  gnt;
    logic        busy;
    logic [3:0]  an;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [2:0] prev_gnt = 3'b000;

    typedef struct {
        logic [2:0] gnt;
        int         cyc;
    } gexp_t;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] seg;
        logic       busy;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    seg_display_arbiter #(
        .REFRESH_DIV(17'd4),
        .SLOT_FRAMES(16'd2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .disp0(disp0),
        .disp1(disp1),
        .disp2(disp2),
        .gnt  (gnt),
        .busy (busy),
        .an   (an),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: after the k-th rising edge cyc == k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_gnt = gnt;
        end else begin
            if (gnt !== prev_gnt) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL gnt_unexpected: got gnt=%b at cyc %0d, required no change from %b",
                             gnt, cyc, prev_gnt);
                end else begin
                    gexp_t g;
                    g = gq.pop_front();
                    if (gnt !== g.gnt || cyc != g.cyc) begin
                        errors++;
                        $display("FAIL gnt_change: got gnt=%b at cyc %0d, required gnt=%b at cyc %0d",
                                 gnt, cyc, g.gnt, g.cyc);
                    end
                end
                prev_gnt = gnt;
            end
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                dexp_t d;
                d = dq.pop_front();
                checks++;
                if (an !== d.an || seg !== d.seg || busy !== d.busy) begin
                    errors++;
                    $display("FAIL display cyc %0d: got an=%b seg=%h busy=%b, required an=%b seg=%h busy=%b",
                             cyc, an, seg, busy, d.an, d.seg, d.busy);
                end
            end
        end
    end

    task automatic push_g(input logic [2:0] g, input int c);
        gexp_t e;
        e.gnt = g;
        e.cyc = c;
        gq.push_back(e);
    endtask

    task automatic push_d(input int c, input logic [3:0] a, input logic [7:0] s, input logic b);
        dexp_t e;
        e.cyc  = c;
        e.an   = a;
        e.seg  = s;
        e.busy = b;
        dq.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt, busy, an, seg} !== {3'b000, 1'b0, 4'hF, 8'hFF}) begin
                errors++;
                $display("FAIL reset_state: got gnt=%b busy=%b an=%b seg=%h, required 000 0 1111 ff",
                         gnt, busy, an, seg);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic end_seg(input string name);
        checks++;
        if (gq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d grant and %0d display expectations unmet, required 0",
                     name, gq.size(), dq.size());
            gq.delete();
            dq.delete();
        end
    endtask

    initial begin
        logic [3:0] an_lut [4];
        logic [7:0] seg0_lut [4];
        an_lut   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg0_lut = '{8'hB0, 8'hA4, 8'hF9, 8'hC0};

        // Single owner, then two-source alternation, then owner drops out.
        req = 3'b111;
        push_g(3'b001, 1);
        push_g(3'b000, 169);
        push_g(3'b010, 172);
        push_g(3'b000, 193);
        push_g(3'b001, 196);
        push_g(3'b000, 225);
        push_g(3'b010, 228);
        push_g(3'b000, 231);
        for (int c = 1; c <= 20; c++)
            push_d(c, an_lut[(c / 4) % 4], seg0_lut[(c / 4) % 4], 1'b1);
        push_d(170, 4'hF, 8'hFF, 1'b1);
        push_d(172, 4'b0111, 8'h86, 1'b1);
        push_d(196, 4'b1101, 8'hA4, 1'b1);
        push_d(231, 4'hF, 8'hFF, 1'b1);
        push_d(232, 4'hF, 8'hFF, 1'b0);
        do_reset();
        wait_cyc(1);
        req = 3'b001;
        wait_cyc(168);
        req = 3'b011;
        wait_cyc(230);
        req = 3'b000;
        wait_cyc(236);
        end_seg("two_src");

        // Owner releases mid-frame: one blank slot, then idle.
        req = 3'b001;
        push_g(3'b001, 1);
        push_g(3'b000, 7);
        push_d(7, 4'hF, 8'hFF, 1'b1);
        push_d(8, 4'hF, 8'hFF, 1'b0);
        do_reset();
        wait_cyc(6);
        req = 3'b000;
        wait_cyc(12);
        end_seg("release");

        // Three-way rotation; source 1 drops out during a blank slot.
        req = 3'b111;
        push_g(3'b001, 1);
        push_g(3'b000, 33);
        push_g(3'b010, 36);
        push_g(3'b000, 65);
        push_g(3'b100, 68);
        push_g(3'b000, 97);
        push_g(3'b001, 100);
        push_g(3'b000, 129);
        push_g(3'b100, 132);
        push_g(3'b000, 161);
        push_g(3'b001, 164);
        push_d(130, 4'hF, 8'hFF, 1'b1);
        push_d(132, 4'b1101, 8'h56, 1'b1);
        do_reset();
        wait_cyc(129);
        req = 3'b101;
        wait_cyc(170);
        end_seg("three_src");

        // Asynchronous reset while owning, then fresh arbitration.
        req = 3'b001;
        push_g(3'b001, 1);
        do_reset();
        wait_cyc(5);
        end_seg("pre_async");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, an, seg} !== {3'b000, 1'b0, 4'hF, 8'hFF}) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b busy=%b an=%b seg=%h, required 000 0 1111 ff",
                     gnt, busy, an, seg);
        end
        req = 3'b110;
        push_g(3'b010, 1);
        push_d(1, 4'b1110, 8'hA1, 1'b1);
        do_reset();
        wait_cyc(6);
        end_seg("post_async");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
